// File: rtl/dp_ram_pkg.sv
// dp_ram_pkg: shared definitions for the dual-port RAM model.
//  - nb_of():      byte-lane count for a data width
//  - byte_merge(): (old, new, low-active wen) -> merged word, sized for the
//                  widest supported word; callers cast to their own width
//  - RAM_RD_LAT:   read latency, 2 with RAM_DOUT_REG_EN defined, else 1
// Optional feature macro: RAM_DOUT_REG_EN
package dp_ram_pkg;

  localparam int MAX_DW = 256;
  localparam int MAX_NB = MAX_DW / 8;

`ifdef RAM_DOUT_REG_EN
  localparam int RAM_RD_LAT = 2;
`else
  localparam int RAM_RD_LAT = 1;
`endif

  function automatic int nb_of(input int dw);
    return dw / 8;
  endfunction

  // wen[i]=0 takes byte i from new_w, wen[i]=1 keeps byte i of old_w.
  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] old_w,
                                                   input logic [MAX_DW-1:0] new_w,
                                                   input logic [MAX_NB-1:0] wen);
    logic [MAX_DW-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_NB; i++)
      if (!wen[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/dp_ram_if.sv
// dp_ram_if: one RAM port.
//  addr   word address            cen    chip enable, active low
//  wen    byte write enables, active low (bit i -> byte i)
//  din    write data              dout   read data
//  dvalid read data valid strobe
// master = requester side, slave = RAM side.
interface dp_ram_if
  import dp_ram_pkg::*;
#(
  parameter int ADDR_MSB   = 6,
  parameter int DATA_WIDTH = 16
);
  localparam int NB = nb_of(DATA_WIDTH);

  logic [ADDR_MSB:0]   addr;
  logic                cen;
  logic [NB-1:0]       wen;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                dvalid;

  modport master (output addr, cen, wen, din, input dout, dvalid);
  modport slave  (input addr, cen, wen, din, output dout, dvalid);
endinterface

// File: rtl/dp_ram_port.sv
// dp_ram_port: per-port read side of dp_ram.
//  clk, rst_n      clock, synchronous active-low reset
//  addr, cen, wen  port request (wen only matters for "is this a pure read")
//  rd_word         mem[addr_reg], supplied by the array owner
//  addr_reg        registered address of the last enabled access
//  dout, dvalid    read data and strobe
// With RAM_DOUT_REG_EN defined a further output register delays dout/dvalid
// by one cycle; that register only loads when a read completes.
module dp_ram_port
  import dp_ram_pkg::*;
#(
  parameter int ADDR_MSB   = 6,
  parameter int DATA_WIDTH = 16,
  localparam int NB        = nb_of(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_MSB:0]     addr,
  input  logic                  cen,
  input  logic [NB-1:0]         wen,
  input  logic [DATA_WIDTH-1:0] rd_word,
  output logic [ADDR_MSB:0]     addr_reg,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dvalid
);

  logic                  rd_req;
  logic [RAM_RD_LAT-1:0] vld_pipe;

  assign rd_req = ~cen & (&wen);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_reg <= '0;
      vld_pipe <= '0;
    end else begin
      if (!cen) addr_reg <= addr;
      vld_pipe <= RAM_RD_LAT'({vld_pipe, rd_req});
    end
  end

  assign dvalid = vld_pipe[RAM_RD_LAT-1];

`ifdef RAM_DOUT_REG_EN
  logic [DATA_WIDTH-1:0] dout_q;

  // vld_pipe[0] marks the cycle in which rd_word is the requested word.
  always_ff @(posedge clk) begin
    if (!rst_n)           dout_q <= '0;
    else if (vld_pipe[0]) dout_q <= rd_word;
  end

  assign dout = dout_q;
`else
  // Write-first by construction: rd_word follows the array continuously.
  assign dout = rd_word;
`endif

endmodule

// File: rtl/dp_ram.sv
// dp_ram: true dual-port synchronous RAM model, one clock, one array.
//  ram_clk        clock, rising edge
//  ram_rst_n      synchronous reset, active low (array contents are kept)
//  ram_a          port A (CPU side), dp_ram_if.slave
//  ram_b          port B (DMA/debug side), dp_ram_if.slave
//  ram_collision  sticky: same-address access with at least one write
// Parameters: ADDR_MSB (depth = 1<<(ADDR_MSB+1)), DATA_WIDTH (multiple of 8),
//  INIT_ZERO (power-up clearing is left to the simulator/FPGA init flow; the
//  RTL only range-checks it, array contents start undefined here).
// Optional feature macro: RAM_DOUT_REG_EN (registered outputs, latency 2).
// On a same-address double write, lanes written by both ports take port A data.
module dp_ram
  import dp_ram_pkg::*;
#(
  parameter int ADDR_MSB   = 6,
  parameter int DATA_WIDTH = 16,
  parameter int INIT_ZERO  = 0
) (
  input  logic    ram_clk,
  input  logic    ram_rst_n,
  dp_ram_if.slave ram_a,
  dp_ram_if.slave ram_b,
  output logic    ram_collision
);

  localparam int NB    = nb_of(DATA_WIDTH);
  localparam int DEPTH = 1 << (ADDR_MSB + 1);

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > MAX_DW || INIT_ZERO < 0 || INIT_ZERO > 1)
  begin : g_bad_cfg
    $error("dp_ram: unsupported parameter set");
  end

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_w,
                                                  input logic [DATA_WIDTH-1:0] new_w,
                                                  input logic [NB-1:0]         wen);
    // Unused upper lanes are forced to "keep".
    return DATA_WIDTH'(byte_merge(MAX_DW'(old_w), MAX_DW'(new_w), ~MAX_NB'(~wen)));
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  a_acc, b_acc, a_wr, b_wr, same_addr, coll;
  logic [ADDR_MSB:0]     a_addr_reg, b_addr_reg;
  logic [DATA_WIDTH-1:0] a_rd_word, b_rd_word;

  // Accesses in the reset cycle are dropped.
  assign a_acc     = ram_rst_n & ~ram_a.cen;
  assign b_acc     = ram_rst_n & ~ram_b.cen;
  assign a_wr      = a_acc & ~(&ram_a.wen);
  assign b_wr      = b_acc & ~(&ram_b.wen);
  assign same_addr = ram_a.addr == ram_b.addr;
  assign coll      = a_acc & b_acc & same_addr & (a_wr | b_wr);

  always_ff @(posedge ram_clk) begin
    if (a_wr && b_wr && same_addr) begin
      // B merged first, A on top: A owns the lanes both ports write.
      mem[ram_a.addr] <= merge(merge(mem[ram_a.addr], ram_b.din, ram_b.wen),
                               ram_a.din, ram_a.wen);
    end else begin
      if (a_wr) mem[ram_a.addr] <= merge(mem[ram_a.addr], ram_a.din, ram_a.wen);
      if (b_wr) mem[ram_b.addr] <= merge(mem[ram_b.addr], ram_b.din, ram_b.wen);
    end
  end

  always_ff @(posedge ram_clk) begin
    if (!ram_rst_n) ram_collision <= 1'b0;
    else if (coll)  ram_collision <= 1'b1;
  end

  assign a_rd_word = mem[a_addr_reg];
  assign b_rd_word = mem[b_addr_reg];

  dp_ram_port #(.ADDR_MSB(ADDR_MSB), .DATA_WIDTH(DATA_WIDTH)) u_port_a (
    .clk      (ram_clk),
    .rst_n    (ram_rst_n),
    .addr     (ram_a.addr),
    .cen      (ram_a.cen),
    .wen      (ram_a.wen),
    .rd_word  (a_rd_word),
    .addr_reg (a_addr_reg),
    .dout     (ram_a.dout),
    .dvalid   (ram_a.dvalid)
  );

  dp_ram_port #(.ADDR_MSB(ADDR_MSB), .DATA_WIDTH(DATA_WIDTH)) u_port_b (
    .clk      (ram_clk),
    .rst_n    (ram_rst_n),
    .addr     (ram_b.addr),
    .cen      (ram_b.cen),
    .wen      (ram_b.wen),
    .rd_word  (b_rd_word),
    .addr_reg (b_addr_reg),
    .dout     (ram_b.dout),
    .dvalid   (ram_b.dvalid)
  );

endmodule

// File: tb/tb_dp_ram.sv
// tb_dp_ram: scoreboard bench for dp_ram. The driver applies each edge's
// requests to a word-array model and queues the expected read word with the
// cycle it must appear in; a negedge monitor pops and compares on dvalid.
// With RAM_DOUT_REG_EN defined the bench uses ADDR_MSB=9, DATA_WIDTH=32.
module tb_dp_ram;

`ifdef RAM_DOUT_REG_EN
  localparam int AM = 9, DW = 32, LAT = 2;
`else
  localparam int AM = 6, DW = 16, LAT = 1;
`endif
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << (AM + 1);

  typedef struct {
    logic          cen;
    logic [NB-1:0] wen;
    logic [AM:0]   addr;
    logic [DW-1:0] din;
  } preq_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic col;

  dp_ram_if #(.ADDR_MSB(AM), .DATA_WIDTH(DW)) a_if ();
  dp_ram_if #(.ADDR_MSB(AM), .DATA_WIDTH(DW)) b_if ();

  dp_ram #(.ADDR_MSB(AM), .DATA_WIDTH(DW), .INIT_ZERO(0)) dut (
    .ram_clk       (clk),
    .ram_rst_n     (rst_n),
    .ram_a         (a_if),
    .ram_b         (b_if),
    .ram_collision (col)
  );

  always #5 clk = ~clk;

  int            edge_n = 0;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mdl [DEPTH];
  bit            col_exp = 1'b0;
  exp_t          q [2][$];

  always @(posedge clk) edge_n++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: each expected read must show up exactly in its due cycle.
  bit            m_v;
  logic [DW-1:0] m_d;
  exp_t          m_x;
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      m_v = (p == 0) ? a_if.dvalid : b_if.dvalid;
      m_d = (p == 0) ? a_if.dout   : b_if.dout;
      if (q[p].size() > 0 && q[p][0].due == edge_n) begin
        m_x = q[p].pop_front();
        checks++;
        if (m_v !== 1'b1 || m_d !== m_x.data) begin
          errors++;
          $display("FAIL read port%0d cycle %0d: dvalid=%b dout=%h required dvalid=1 dout=%h",
                   p, edge_n, m_v, m_d, m_x.data);
        end
      end else if (m_v !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL spurious dvalid port%0d cycle %0d: dvalid=%b required 0", p, edge_n, m_v);
      end
    end
  end

  function automatic preq_t idle();
    return '{cen: 1'b1, wen: '1, addr: '0, din: '0};
  endfunction
  function automatic preq_t rd(input int a);
    return '{cen: 1'b0, wen: '1, addr: (AM+1)'(a), din: '0};
  endfunction
  function automatic preq_t wr(input int a, input logic [DW-1:0] d, input logic [NB-1:0] w);
    return '{cen: 1'b0, wen: w, addr: (AM+1)'(a), din: d};
  endfunction

  task automatic model_write(input preq_t r);
    for (int i = 0; i < NB; i++)
      if (!r.wen[i]) mdl[r.addr][i*8 +: 8] = r.din[i*8 +: 8];
  endtask

  // Called #1 after a rising edge; requests take effect at the next edge.
  task automatic step(input bit rv, input preq_t a, input preq_t b);
    int   e;
    bit   col_next;
    rst_n = rv;
    a_if.cen = a.cen; a_if.wen = a.wen; a_if.addr = a.addr; a_if.din = a.din;
    b_if.cen = b.cen; b_if.wen = b.wen; b_if.addr = b.addr; b_if.din = b.din;
    e = edge_n + 1;
    col_next = col_exp;
    if (!rv) begin
      col_next = 1'b0;
      for (int p = 0; p < 2; p++)
        while (q[p].size() > 0 && q[p][$].due >= e) void'(q[p].pop_back());
    end else begin
      if (!a.cen && !b.cen && a.addr == b.addr && (a.wen != '1 || b.wen != '1))
        col_next = 1'b1;
      if (!b.cen) model_write(b);
      if (!a.cen) model_write(a);  // applied last: A wins shared lanes
      if (!a.cen && a.wen == '1) q[0].push_back('{due: e + LAT - 1, data: mdl[a.addr]});
      if (!b.cen && b.wen == '1) q[1].push_back('{due: e + LAT - 1, data: mdl[b.addr]});
    end
    @(posedge clk);
    #1;
    col_exp = col_next;
    chk("collision", col, col_exp);
  endtask

  task automatic rd_check(input int p, input int a, input logic [DW-1:0] exp, input string name);
    if (p == 0) step(1, rd(a), idle());
    else        step(1, idle(), rd(a));
    repeat (LAT - 1) step(1, idle(), idle());
    chk({name, " dvalid"}, (p == 0) ? a_if.dvalid : b_if.dvalid, 1);
    chk(name, (p == 0) ? a_if.dout : b_if.dout, exp);
  endtask

  preq_t ra, rb;

  function automatic preq_t rand_req();
    preq_t r;
    r.cen  = ($urandom_range(0, 9) < 3);
    r.wen  = ($urandom_range(0, 1) == 0) ? '1 : NB'($urandom);
    r.addr = ($urandom_range(0, 9) < 3) ? (AM+1)'($urandom_range(0, 3)) : (AM+1)'($urandom);
    r.din  = DW'($urandom);
    return r;
  endfunction

  initial begin
    rst_n = 1'b0;
    a_if.cen = 1'b1; a_if.wen = '1; a_if.addr = '0; a_if.din = '0;
    b_if.cen = 1'b1; b_if.wen = '1; b_if.addr = '0; b_if.din = '0;
    @(posedge clk);
    #1;

    // Reset state
    step(0, idle(), idle());
    step(0, idle(), idle());
    chk("reset a dvalid", a_if.dvalid, 0);
    chk("reset b dvalid", b_if.dvalid, 0);
`ifdef RAM_DOUT_REG_EN
    chk("reset a dout", a_if.dout, 0);
    chk("reset b dout", b_if.dout, 0);
`endif

    // Fill: A even words, B odd words, same edge
    for (int i = 0; i < DEPTH; i += 2)
      step(1, wr(i, DW'($urandom), '0), wr(i + 1, DW'($urandom), '0));

    // 1: full write then read
    step(1, wr(5, 'h1234, '0), idle());
    rd_check(0, 5, 'h1234, "t1 full write");

    // 2: byte writes
    step(1, wr(5, 'hABCD, ~NB'(2)), idle());
    rd_check(0, 5, 'hAB34, "t2 upper byte");
    step(1, wr(5, 'hABCD, ~NB'(1)), idle());
    rd_check(0, 5, 'hABCD, "t2 lower byte");

    // 4: cross-port visibility, read/read same address is legal
    step(1, wr(63, 'hBEEF, '0), idle());
    rd_check(1, 63, 'hBEEF, "t4 cross port");
    step(1, rd(63), rd(63));
    step(1, wr(63, 'hC0DE, '0), idle());
`ifdef RAM_DOUT_REG_EN
    chk("t4 b dout holds", b_if.dout, 'hBEEF);
`else
    chk("t4 b dout tracks", b_if.dout, 'hC0DE);
`endif

    // 3: write/write collision, A wins, flag sticky
    step(1, wr(16, 'h1111, '0), wr(16, 'h2222, '0));
    repeat (10) step(1, idle(), idle());
    rd_check(0, 16, 'h1111, "t3 a wins");
    step(1, wr(17, 'h0055, ~NB'(1)), wr(17, 'h6677, '0));
    rd_check(1, 17, 'h6655, "t3 lane merge");

    // 5: reset on a write edge
    step(0, wr(5, 'h5555, '0), idle());
    chk("t5 a dvalid", a_if.dvalid, 0);
    chk("t5 b dvalid", b_if.dvalid, 0);
    step(1, idle(), idle());
    rd_check(0, 5, 'hABCD, "t5 contents intact");

    // 6: top address and back-to-back streaming
    step(1, wr(DEPTH - 1, 'h5A5A, '0), idle());
    rd_check(0, DEPTH - 1, 'h5A5A, "t6 top address");
    for (int i = 0; i < 8; i++) step(1, rd(DEPTH - 1 - i), rd(i));

    // Random traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      ra = rand_req();
      rb = rand_req();
      step(($urandom_range(0, 299) != 0), ra, rb);
    end

    repeat (LAT + 1) step(1, idle(), idle());
    chk("drain port0", q[0].size(), 0);
    chk("drain port1", q[1].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
